// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS-style front end.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT_MOC,
    S_LATCH,
    S_VALID,
    S_ERR
  } fetch_state_t;

  localparam int unsigned OPCODE_MSB       = 31;
  localparam int unsigned OPCODE_LSB       = 26;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_pc_unit.sv
// Program counter: reset value, sequential +4 increment, redirect load has priority.
import mips_pkg::*;

module pc_unit #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_pc,
  input  logic        i_incr,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_load_pc;
    else if (i_incr) r_pc <= r_pc + PC_INCR;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: MAR/MDR handshake with memory, IR latch, redirect flush and MOC timeout.
import mips_pkg::*;

module instr_fetch #(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned MOC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  input  logic        MOC,
  input  logic [31:0] mem_rdata,
  input  logic        instr_ready,
  output logic [31:0] mem_addr,
  output logic        MOV,
  output logic        RW,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = $clog2(MOC_TIMEOUT + 1);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_mar, r_mdr, r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic         r_flush, r_err;
  logic         w_pc_load, w_timeout, w_discard;

  // Redirects are honoured everywhere except the absorbing error state.
  assign w_pc_load = pc_load && (r_state != S_ERR);
  assign w_timeout = !MOC && (r_cnt == CNT_W'(MOC_TIMEOUT - 1));
  assign w_discard = r_flush || pc_load;

  pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_pc_load),
    .i_load_pc (pc_next),
    .i_incr    (r_state == S_LATCH),
    .o_pc      (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (run) w_state_nxt = S_ADDR;
      S_ADDR:     w_state_nxt = pc_load ? S_ADDR : S_WAIT_MOC;
      S_WAIT_MOC: begin
        if (MOC)            w_state_nxt = w_discard ? S_ADDR : S_LATCH;
        else if (w_timeout) w_state_nxt = S_ERR;
      end
      S_LATCH:    w_state_nxt = pc_load ? S_ADDR : S_VALID;
      S_VALID: begin
        if (pc_load)          w_state_nxt = S_ADDR;
        else if (instr_ready) w_state_nxt = run ? S_ADDR : S_IDLE;
      end
      S_ERR:      w_state_nxt = S_ERR;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    MOV         = (r_state == S_WAIT_MOC);
    RW          = (r_state == S_WAIT_MOC);
    instr_valid = (r_state == S_VALID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mar   <= '0;
      r_mdr   <= '0;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_flush <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          r_mar   <= pc;
          r_cnt   <= '0;
          r_flush <= 1'b0;
        end
        S_WAIT_MOC: begin
          if (MOC) begin
            r_mdr   <= mem_rdata;
            r_flush <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (pc_load)   r_flush <= 1'b1;
            if (w_timeout) r_err   <= 1'b1;
          end
        end
        S_LATCH: if (!pc_load) r_ir <= r_mdr;
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mar;
  assign ir        = r_ir;
  assign opcode    = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign fetch_err = r_err;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MOC_TIMEOUT, default 255, maximum cycles to wait for MOC before flagging an error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  enables fetching; sampled in IDLE and at each handshake completion.
REQ-006 pc_load  input  1  redirect request (jump/branch taken).
REQ-007 pc_next  input  32  redirect target, valid while pc_load=1.
REQ-008 MOC  input  1  memory operation complete; mem_rdata valid while high.
REQ-009 mem_rdata  input  32  memory read data.
REQ-010 instr_ready  input  1  downstream decode/control accepts the instruction.
REQ-011 mem_addr  output  32  MAR contents, driven to memory.
REQ-012 MOV  output  1  memory operation valid (request).
REQ-013 RW  output  1  1=read; held 1 whenever MOV=1.
REQ-014 ir  output  32  instruction register.
REQ-015 opcode  output  6  ir[31:26], feeds the control unit.
REQ-016 instr_valid  output  1  ir holds an unconsumed instruction.
REQ-017 pc  output  32  current PC (address of next fetch).
REQ-018 fetch_err  output  1  sticky MOC timeout flag.

Function
REQ-019 FSM states: IDLE, ADDR, WAIT_MOC, LATCH, VALID, ERR.
REQ-020 IDLE: run=1 -> ADDR; else remain.
REQ-021 ADDR: MAR<=pc; -> WAIT_MOC next cycle.
REQ-022 WAIT_MOC: MOV=1, RW=1; cycle MOC sampled high: MDR<=mem_rdata, MOV deasserts next cycle, -> LATCH.
REQ-023 LATCH: ir<=MDR, pc<=pc+4 (modulo 2^32, wraps 32'hFFFF_FFFC->0); -> VALID.
REQ-024 VALID: instr_valid=1, ir stable; on instr_valid&&instr_ready -> ADDR if run=1, else IDLE.
REQ-025 Minimum latency: run sampled high in IDLE with MOC high on first MOV cycle -> instr_valid high 4 cycles later.
REQ-026 pc_load in IDLE, ADDR, LATCH or VALID: pc<=pc_next that edge, overriding pc+4; LATCH/VALID contents discarded, instr_valid drops next cycle, -> ADDR (IDLE stays IDLE).
REQ-027 pc_load in VALID coincident with instr_ready: handshake completes (instruction consumed), pc<=pc_next, -> ADDR regardless of run.
REQ-028 pc_load in WAIT_MOC: pc<=pc_next, flush flag set; MOV held until MOC (bus transaction never aborted); returned data discarded, -> ADDR; no instr_valid for flushed fetch.
REQ-029 Timeout counter clears on entry to WAIT_MOC, increments each WAIT_MOC cycle without MOC; reaching MOC_TIMEOUT -> MOV=0, fetch_err=1, -> ERR.
REQ-030 ERR: absorbing; all outputs frozen except MOV=0, instr_valid=0; exit only by reset.
REQ-031 MOC outside WAIT_MOC ignored.
REQ-032 opcode is combinational slice of ir; no additional latency.

Reset
REQ-033 reset asserted: state=IDLE, pc=RESET_PC, mem_addr=0, ir=0, MDR=0, MOV=0, RW=0, instr_valid=0, fetch_err=0, counter=0, flush=0, immediately (asynchronous).
REQ-034 Reset mid-transaction (WAIT_MOC) drops MOV at once; late MOC after release is ignored per REQ-031.
REQ-035 First fetch after reset release requires run=1 sampled on a clock edge.

Structure
REQ-036 Shared package mips_pkg holds: fetch state enum, OPCODE_MSB/LSB (31/26), PC_INCR (4), RESET_PC default.
REQ-037 One sub-module, pc_unit: PC register with reset value, +4 increment and pc_load override.
REQ-038 Timeout counter width is $clog2(MOC_TIMEOUT+1).

Verification
REQ-039 Reset, run=1, MOC returns 32'h2000_0005 on first MOV cycle -> mem_addr=0, instr_valid at cycle 4, opcode=6'b001000, pc=4.
REQ-040 instr_ready held low 10 cycles -> ir stable, MOV=0, pc unchanged; ready=1 -> next fetch from mem_addr=4.
REQ-041 pc_load=1, pc_next=32'h0000_0100 during WAIT_MOC, MOC 3 cycles later -> no instr_valid for that data, next MOV with mem_addr=32'h100.
REQ-042 pc_load and instr_ready same cycle in VALID, run=0 -> instruction consumed once, pc=pc_next, fetch starts (ADDR).
REQ-043 MOC never asserted -> after 255 WAIT_MOC cycles MOV=0, fetch_err=1 sticky; reset clears.
REQ-044 pc=32'hFFFF_FFFC fetch completes -> pc=0.
